// File: rtl/bram1be_arbiter.sv
// Two-client round-robin arbiter for a single-port byte-enable BRAM.
// Read responses are credit-reserved and returned through per-client FIFOs.
module bram1be_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int WE_WIDTH   = 4,
  parameter int PIPELINED  = 0,
  parameter int RESP_DEPTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_a_req_valid,
  output logic                  o_a_req_ready,
  input  logic [WE_WIDTH-1:0]   i_a_req_we,
  input  logic [ADDR_WIDTH-1:0] i_a_req_addr,
  input  logic [DATA_WIDTH-1:0] i_a_req_di,
  output logic                  o_a_rsp_valid,
  input  logic                  i_a_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_a_rsp_data,
  input  logic                  i_b_req_valid,
  output logic                  o_b_req_ready,
  input  logic [WE_WIDTH-1:0]   i_b_req_we,
  input  logic [ADDR_WIDTH-1:0] i_b_req_addr,
  input  logic [DATA_WIDTH-1:0] i_b_req_di,
  output logic                  o_b_rsp_valid,
  input  logic                  i_b_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_b_rsp_data,
  output logic                  o_bram_en,
  output logic [WE_WIDTH-1:0]   o_bram_we,
  output logic [ADDR_WIDTH-1:0] o_bram_addr,
  output logic [DATA_WIDTH-1:0] o_bram_di,
  input  logic [DATA_WIDTH-1:0] i_bram_do
);

  localparam int L  = 1 + PIPELINED;
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  logic [1:0]            w_valid, w_is_rd, w_elig, w_gnt, w_rd_gnt;
  logic [1:0]            w_push, w_pop, w_rsp_valid, w_rsp_ready, w_has_cred;
  logic [DATA_WIDTH-1:0] w_rsp_data [2];
  logic                  r_ptr;
  logic [L-1:0]          r_pv, r_pid;

  assign w_valid     = {i_b_req_valid, i_a_req_valid};
  assign w_is_rd     = {~|i_b_req_we, ~|i_a_req_we};
  assign w_rsp_ready = {i_b_rsp_ready, i_a_rsp_ready};
  assign w_elig      = w_valid & (~w_is_rd | w_has_cred);

  // Grants are gated by reset so every request-side output drops the moment reset asserts.
  assign w_gnt[0] = i_rst_n & w_elig[0] & (~w_elig[1] | ~r_ptr);
  assign w_gnt[1] = i_rst_n & w_elig[1] & (~w_elig[0] |  r_ptr);
  assign w_rd_gnt = w_gnt & w_is_rd;

  assign o_a_req_ready = w_gnt[0];
  assign o_b_req_ready = w_gnt[1];
  assign o_bram_en     = |w_gnt;
  assign o_bram_we     = w_gnt[0] ? i_a_req_we : (w_gnt[1] ? i_b_req_we : '0);
  assign o_bram_addr   = w_gnt[1] ? i_b_req_addr : i_a_req_addr;
  assign o_bram_di     = w_gnt[1] ? i_b_req_di   : i_a_req_di;

  assign o_a_rsp_valid = w_rsp_valid[0];
  assign o_b_rsp_valid = w_rsp_valid[1];
  assign o_a_rsp_data  = w_rsp_data[0];
  assign o_b_rsp_data  = w_rsp_data[1];

  // r_ptr = 0 gives A priority; it flips to the loser after every grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= 1'b0;
      r_pv  <= '0;
      r_pid <= '0;
    end else begin
      if (|w_gnt) r_ptr <= w_gnt[0];
      r_pv[0]  <= |w_rd_gnt;
      r_pid[0] <= w_rd_gnt[1];
      for (int i = 1; i < L; i++) begin
        r_pv[i]  <= r_pv[i-1];
        r_pid[i] <= r_pid[i-1];
      end
    end
  end

  assign w_push[0] = r_pv[L-1] & ~r_pid[L-1];
  assign w_push[1] = r_pv[L-1] &  r_pid[L-1];

  function automatic logic [PW-1:0] f_nxt(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  for (genvar c = 0; c < 2; c++) begin : g_cl
    logic [DATA_WIDTH-1:0] r_mem [RESP_DEPTH];
    logic [PW-1:0]         r_rd, r_wr;
    logic [CW-1:0]         r_cnt, r_cred;

    assign w_rsp_valid[c] = (r_cnt != '0);
    assign w_pop[c]       = w_rsp_valid[c] & w_rsp_ready[c];
    assign w_rsp_data[c]  = r_mem[r_rd];
    assign w_has_cred[c]  = (r_cred != '0);

    always_ff @(posedge i_clk) begin
      if (w_push[c]) r_mem[r_wr] <= i_bram_do;
    end

    // Credits + FIFO occupancy + reads in flight always sum to RESP_DEPTH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_rd   <= '0;
        r_wr   <= '0;
        r_cnt  <= '0;
        r_cred <= CW'(RESP_DEPTH);
      end else begin
        if (w_push[c]) r_wr <= f_nxt(r_wr);
        if (w_pop[c])  r_rd <= f_nxt(r_rd);
        r_cnt  <= r_cnt + CW'(w_push[c]) - CW'(w_pop[c]);
        r_cred <= r_cred + CW'(w_pop[c]) - CW'(w_rd_gnt[c]);
      end
    end
  end

endmodule

// File: tb/tb_bram1be_arbiter.sv
// Directed bench for bram1be_arbiter: one non-pipelined and one pipelined instance,
// each driving a behavioural byte-enable BRAM owned by the bench.
module tb_bram1be_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_v = 0, a_rr = 0, b_v = 0, b_rr = 0;
  logic [3:0]  a_we = 0, b_we = 0;
  logic [9:0]  a_addr = 0, b_addr = 0;
  logic [31:0] a_di = 0, b_di = 0;
  logic        a_rdy, a_rv, b_rdy, b_rv, en;
  logic [31:0] a_rd, b_rd, di, do0;
  logic [3:0]  we;
  logic [9:0]  addr;

  logic        p_v = 0, p_rr = 0;
  logic [9:0]  p_addr = 0;
  logic        p_rdy, p_rv, pb_rdy, pb_rv, p_en;
  logic [31:0] p_rd, pb_rd, p_di, do1q, do1;
  logic [3:0]  p_we;
  logic [9:0]  p_baddr;

  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [1024];
  logic [31:0] qa[$], qb[$], qp[$];
  int n_chk = 0, n_err = 0;

  bram1be_arbiter #(.PIPELINED(0), .RESP_DEPTH(2)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_req_valid(a_v), .o_a_req_ready(a_rdy), .i_a_req_we(a_we), .i_a_req_addr(a_addr),
    .i_a_req_di(a_di), .o_a_rsp_valid(a_rv), .i_a_rsp_ready(a_rr), .o_a_rsp_data(a_rd),
    .i_b_req_valid(b_v), .o_b_req_ready(b_rdy), .i_b_req_we(b_we), .i_b_req_addr(b_addr),
    .i_b_req_di(b_di), .o_b_rsp_valid(b_rv), .i_b_rsp_ready(b_rr), .o_b_rsp_data(b_rd),
    .o_bram_en(en), .o_bram_we(we), .o_bram_addr(addr), .o_bram_di(di), .i_bram_do(do0)
  );

  bram1be_arbiter #(.PIPELINED(1), .RESP_DEPTH(4)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_req_valid(p_v), .o_a_req_ready(p_rdy), .i_a_req_we(4'h0), .i_a_req_addr(p_addr),
    .i_a_req_di(32'h0), .o_a_rsp_valid(p_rv), .i_a_rsp_ready(p_rr), .o_a_rsp_data(p_rd),
    .i_b_req_valid(1'b0), .o_b_req_ready(pb_rdy), .i_b_req_we(4'h0), .i_b_req_addr(10'h0),
    .i_b_req_di(32'h0), .o_b_rsp_valid(pb_rv), .i_b_rsp_ready(1'b1), .o_b_rsp_data(pb_rd),
    .o_bram_en(p_en), .o_bram_we(p_we), .o_bram_addr(p_baddr), .o_bram_di(p_di), .i_bram_do(do1)
  );

  always @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++)
        if (we[i]) mem0[addr][i*8 +: 8] <= di[i*8 +: 8];
      do0 <= mem0[addr];
    end
  end

  always @(posedge clk) begin
    if (p_en) do1q <= mem1[p_baddr];
    do1 <= do1q;
  end

  always @(negedge clk) begin
    #2;
    if (rst_n && a_rv && a_rr) qa.push_back(a_rd);
    if (rst_n && b_rv && b_rr) qb.push_back(b_rd);
    if (rst_n && p_rv && p_rr) qp.push_back(p_rd);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; a_v = 0; b_v = 0; p_v = 0; a_rr = 0; b_rr = 0; p_rr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic issue(input bit c, input logic [3:0] w, input logic [9:0] ad, input logic [31:0] d);
    bit ok;
    ok = 0;
    @(negedge clk);
    if (c == 0) begin a_v = 1; a_we = w; a_addr = ad; a_di = d; end
    else        begin b_v = 1; b_we = w; b_addr = ad; b_di = d; end
    for (int i = 0; i < 8 && !ok; i++) begin
      #1;
      if ((c == 0) ? a_rdy : b_rdy) ok = 1;
      else @(negedge clk);
    end
    chk("issue_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    a_v = 0; b_v = 0;
  endtask

  task automatic expect_rsp(input bit c, input logic [31:0] exp);
    bit ok;
    logic [31:0] got;
    ok = 0; got = 'x;
    @(negedge clk);
    if (c == 0) a_rr = 1; else b_rr = 1;
    for (int i = 0; i < 8 && !ok; i++) begin
      #1;
      if ((c == 0) ? a_rv : b_rv) begin ok = 1; got = (c == 0) ? a_rd : b_rd; end
      else @(negedge clk);
    end
    chk("rsp_timeout", 32'(ok), 32'd1);
    chk("rsp_data", got, exp);
    @(posedge clk); #1;
    a_rr = 0; b_rr = 0;
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) begin mem0[k] = 32'h0; mem1[k] = 32'h0; end
    for (int k = 0; k < 4; k++) begin
      mem0[10'h100 + k] = 32'hA000_0000 + k;
      mem0[10'h200 + k] = 32'hB000_0000 + k;
      mem1[10'h050 + k] = 32'hC000_0000 + k;
    end
    mem1[10'h040] = 32'hCAFE_F00D;

    // Requests present while in reset must not be granted.
    a_v = 1; b_v = 1; b_we = 4'hF;
    #13;
    chk("rst_a_ready", 32'(a_rdy), 0);
    chk("rst_b_ready", 32'(b_rdy), 0);
    chk("rst_en", 32'(en), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_a_rsp_valid", 32'(a_rv), 0);
    chk("rst_b_rsp_valid", 32'(b_rv), 0);
    a_v = 0; b_v = 0; b_we = 0;
    @(negedge clk); rst_n = 1;

    // Single write then read, latency 2.
    @(negedge clk);
    a_v = 1; a_we = 4'hF; a_addr = 10'h010; a_di = 32'h1122_3344;
    #1;
    chk("wr_ready", 32'(a_rdy), 1);
    chk("wr_en", 32'(en), 1);
    chk("wr_we", 32'(we), 32'hF);
    chk("wr_addr", 32'(addr), 32'h010);
    chk("wr_di", di, 32'h1122_3344);
    @(posedge clk); #1; a_v = 0;
    @(negedge clk);
    a_v = 1; a_we = 4'h0; a_addr = 10'h010;
    #1;
    chk("rd_ready", 32'(a_rdy), 1);
    chk("rd_we", 32'(we), 0);
    @(posedge clk); #1; a_v = 0;
    @(negedge clk); #1;
    chk("rd_lat1_valid", 32'(a_rv), 0);
    @(negedge clk); #1;
    chk("rd_lat2_valid", 32'(a_rv), 1);
    chk("rd_lat2_data", a_rd, 32'h1122_3344);
    chk("rd_b_valid", 32'(b_rv), 0);
    a_rr = 1;
    @(posedge clk); #1; a_rr = 0;
    @(negedge clk); #1;
    chk("rd_popped", 32'(a_rv), 0);

    // Byte merge across clients.
    issue(0, 4'hF, 10'h020, 32'hAABB_CCDD);
    issue(1, 4'h5, 10'h020, 32'h0011_0022);
    issue(0, 4'h0, 10'h020, 32'h0);
    expect_rsp(0, 32'hAA11_CC22);
    chk("merge_b_valid", 32'(b_rv), 0);

    // Contention: reads alternate starting with A.
    do_reset();
    qa.delete(); qb.delete();
    a_rr = 1; b_rr = 1;
    begin
      int na, nb;
      na = 0; nb = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        a_v = 1; a_we = 0; a_addr = 10'h100 + 10'(na);
        b_v = 1; b_we = 0; b_addr = 10'h200 + 10'(nb);
        #1;
        chk("cont_grant_a", 32'(a_rdy), 32'(i % 2 == 0));
        chk("cont_grant_b", 32'(b_rdy), 32'(i % 2 == 1));
        if (a_rdy) na++;
        if (b_rdy) nb++;
      end
    end
    @(posedge clk); #1; a_v = 0; b_v = 0;
    repeat (4) @(negedge clk);
    chk("cont_a_count", qa.size(), 4);
    chk("cont_b_count", qb.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("cont_a_data", (k < qa.size()) ? qa[k] : 32'hx, 32'hA000_0000 + k);
      chk("cont_b_data", (k < qb.size()) ? qb[k] : 32'hx, 32'hB000_0000 + k);
    end

    // Backpressure: A stalls at 2 credits, B writes keep flowing.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a_v = 1; a_we = 0; a_addr = 10'h100;
      b_v = 1; b_we = 4'hF; b_addr = 10'h300; b_di = 32'(i);
      #1;
      chk("bp_grant_a", 32'(a_rdy), 32'(i == 0 || i == 2));
      chk("bp_grant_b", 32'(b_rdy), 32'(i != 0 && i != 2));
    end
    @(negedge clk);
    a_rr = 1;
    #1;
    chk("bp_pop_ready", 32'(a_rdy), 0);
    chk("bp_pop_valid", 32'(a_rv), 1);
    chk("bp_pop_data", a_rd, 32'hA000_0000);
    @(negedge clk);
    a_rr = 0;
    #1;
    chk("bp_regrant_a", 32'(a_rdy), 1);
    chk("bp_regrant_b", 32'(b_rdy), 0);
    @(negedge clk); #1;
    chk("bp_stall_a", 32'(a_rdy), 0);
    chk("bp_stall_b", 32'(b_rdy), 1);
    @(posedge clk); #1; a_v = 0; b_v = 0;

    // Reset one cycle after two reads are issued.
    do_reset();
    qa.delete(); qb.delete();
    @(negedge clk);
    a_v = 1; a_we = 0; a_addr = 10'h100;
    #1; chk("mid_rd0", 32'(a_rdy), 1);
    @(negedge clk);
    a_addr = 10'h101;
    #1; chk("mid_rd1", 32'(a_rdy), 1);
    @(negedge clk);
    b_v = 1; b_we = 4'hF; b_addr = 10'h300;
    #1;
    chk("mid_pre_valid", 32'(a_rv), 1);
    rst_n = 0;
    #1;
    chk("mid_rst_a_ready", 32'(a_rdy), 0);
    chk("mid_rst_b_ready", 32'(b_rdy), 0);
    chk("mid_rst_en", 32'(en), 0);
    chk("mid_rst_a_valid", 32'(a_rv), 0);
    repeat (2) @(negedge clk);
    a_v = 0; b_v = 0; rst_n = 1; a_rr = 1; b_rr = 1;
    repeat (4) @(negedge clk);
    chk("mid_stale_a", qa.size(), 0);
    chk("mid_stale_b", qb.size(), 0);
    a_rr = 0; b_rr = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a_v = 1; a_we = 0; a_addr = 10'h100;
      b_v = 1; b_we = 0; b_addr = 10'h200;
      #1;
      chk("mid_grant_a", 32'(a_rdy), 32'(i == 0 || i == 2));
      chk("mid_grant_b", 32'(b_rdy), 32'(i == 1 || i == 3));
    end
    @(posedge clk); #1; a_v = 0; b_v = 0;

    // Pipelined BRAM: latency 3 and one read per cycle.
    @(negedge clk);
    p_v = 1; p_addr = 10'h040;
    #1; chk("p_ready", 32'(p_rdy), 1);
    @(posedge clk); #1; p_v = 0;
    @(negedge clk); #1; chk("p_lat1_valid", 32'(p_rv), 0);
    @(negedge clk); #1; chk("p_lat2_valid", 32'(p_rv), 0);
    @(negedge clk); #1;
    chk("p_lat3_valid", 32'(p_rv), 1);
    chk("p_lat3_data", p_rd, 32'hCAFE_F00D);
    p_rr = 1;
    @(posedge clk); #1;
    qp.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      p_v = 1; p_addr = 10'h050 + 10'(i);
      #1; chk("p_b2b_ready", 32'(p_rdy), 1);
    end
    @(posedge clk); #1; p_v = 0;
    repeat (6) @(negedge clk);
    chk("p_b2b_count", qp.size(), 4);
    for (int k = 0; k < 4; k++)
      chk("p_b2b_data", (k < qp.size()) ? qp[k] : 32'hx, 32'hC000_0000 + k);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bram1be_arbiter.md
Name: bram1be_arbiter

Overview:
Two-client round-robin arbiter and sequencer for one single-port byte-enable BRAM (ports EN/WE/ADDR/DI/DO, optional output pipeline register).
- Accepts valid/ready requests from clients A and B and issues at most one BRAM access per cycle.
- Tracks in-flight reads through the BRAM read latency and returns read data to the issuing client through a per-client response FIFO.
- Reserves response space (credits) before issuing a read, so no read data is ever dropped.

Parameters:
ADDR_WIDTH, 10, BRAM address width
DATA_WIDTH, 32, BRAM data width
WE_WIDTH, 4, byte-enable count; DATA_WIDTH = WE_WIDTH*8
PIPELINED, 0, 1 when the BRAM has its output register enabled; read latency L = 1 + PIPELINED
RESP_DEPTH, 2, entries per client response FIFO (>= 1)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
A_REQ_VALID  in  1  client A request valid
A_REQ_READY  out  1  client A request accepted this cycle
A_REQ_WE  in  WE_WIDTH  byte write enables; all-zero = read
A_REQ_ADDR  in  ADDR_WIDTH  request address
A_REQ_DI  in  DATA_WIDTH  write data
A_RSP_VALID  out  1  client A read data available
A_RSP_READY  in  1  client A consumes response
A_RSP_DATA  out  DATA_WIDTH  read data
B_REQ_VALID, B_REQ_READY, B_REQ_WE, B_REQ_ADDR, B_REQ_DI, B_RSP_VALID, B_RSP_READY, B_RSP_DATA  same as A, for client B
BRAM_EN  out  1  BRAM enable
BRAM_WE  out  WE_WIDTH  BRAM byte enables
BRAM_ADDR  out  ADDR_WIDTH  BRAM address
BRAM_DI  out  DATA_WIDTH  BRAM write data
BRAM_DO  in  DATA_WIDTH  BRAM read data

Behaviour:
- Reset (RST_N low, asynchronous):
  - All REQ_READY, RSP_VALID and BRAM_EN are 0; BRAM_WE is 0.
  - Response FIFOs are emptied; the in-flight pipeline is cleared.
  - Credits are set to RESP_DEPTH; the priority pointer is set to A.
  - In-flight reads at reset are discarded, and their data is never delivered.
- Eligibility:
  - A request with WE != 0 is a write and is always eligible.
  - A request with WE == 0 is a read and is eligible only if that client's credit > 0.
- Arbitration (combinational, same cycle):
  - If exactly one client is valid and eligible, that client is granted.
  - If both are, the client named by the priority pointer is granted.
  - After any grant, the pointer moves to the other client.
  - If there is no grant, the pointer holds.
  - X_REQ_READY = grant to X. The handshake occurs when VALID and READY are both high at the edge.
- BRAM drive:
  - BRAM_EN = any grant.
  - BRAM_WE, BRAM_ADDR and BRAM_DI are passed through combinationally from the granted client.
  - With no grant, BRAM_EN = 0, BRAM_WE = 0, and ADDR/DI are don't-care.
- Read tracking:
  - A shift register of depth L carries {valid, client_id} for each issued read.
  - Writes insert an invalid entry.
  - When an entry exits the shift register, BRAM_DO is pushed into that client's FIFO on the same edge.
  - Non-pipelined BRAM: request handshake at edge t, push at edge t+1, RSP_VALID high in cycle t+2 (first-word latency 2).
  - Pipelined BRAM: latency 3.
- Credits:
  - Each client has a counter in the range 0..RESP_DEPTH.
  - A read grant decrements the counter; a response pop (RSP_VALID & RSP_READY) increments it.
  - A grant and a pop in the same cycle leave the counter unchanged.
  - The counter never underflows, and no FIFO ever overflows.
- Response FIFO:
  - Order is preserved per client. RSP_DATA is stable while RSP_VALID is high and RSP_READY is low.
  - Push and pop in the same cycle are legal when the FIFO is full or empty. Push into an empty FIFO is not bypassed, so the data is visible the next cycle.
- Ordering and hazards:
  - Accesses are serialized in grant order.
  - A read granted after a write to the same address returns the written bytes merged with the old unwritten bytes.
- Simultaneous events:
  - If client A has zero credit and is issuing a read while B writes, B is granted regardless of the pointer.
  - Writes are never blocked by credits.

Test Plan:
- Single read, PIPELINED=0: A writes WE=4'hF, addr 0x010, DI 0x11223344, then reads 0x010 → A_RSP_DATA 0x11223344 two cycles after the read handshake; B_RSP_VALID stays 0.
- Byte merge: A writes 0xAABBCCDD to 0x020, then B writes WE=4'b0101, DI 0x00110022, then A reads → 0xAA11CC22.
- Contention: A and B both hold VALID with reads for 8 cycles, RSP_READY=1 → grants alternate A, B, A, B... starting with A after reset; each client receives exactly 4 responses, in order.
- Backpressure, RESP_DEPTH=2: A issues reads continuously with A_RSP_READY=0 → exactly 2 handshakes then A_REQ_READY=0; B writes proceed every cycle; raising A_RSP_READY for one pop → exactly one more A read is granted.
- PIPELINED=1: read of a preloaded address → RSP_VALID three cycles after the handshake; back-to-back reads sustain 1 per cycle with RSP_READY=1.
- Reset mid-operation: assert RST_N low one cycle after two reads are issued → all outputs 0 immediately; after release, no stale responses appear, credits are full, and the first contended grant goes to A.
